// File: rtl/fetch_queue.sv
// Decoupled RV32 instruction-fetch front end: DEPTH-entry in-order queue with redirect flush.
// Define FETCH_QUEUE_PERF_EN to add the perfEmptyCycles_o / perfDropped_o counters.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirectPC_i,
  output logic        IMemReqValid_o,
  input  logic        IMemReqReady_i,
  output logic [31:0] IMemAddr_o,
  input  logic        IMemRspValid_i,
  input  logic [31:0] IMemRspData_i,
  output logic        FD_valid_o,
  input  logic        FD_ready_i,
  output logic [31:0] FD_PC_o,
  output logic [31:0] FD_instr_o
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perfEmptyCycles_o,
  output logic [31:0] perfDropped_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      slot_pc_q    [DEPTH];
  logic [31:0]      slot_pc_d    [DEPTH];
  logic [31:0]      slot_instr_q [DEPTH];
  logic [31:0]      slot_instr_d [DEPTH];
  logic [DEPTH-1:0] slot_filled_q, slot_filled_d;
  ptr_t             head_q, head_d;
  ptr_t             fill_q, fill_d;
  ptr_t             tail_q, tail_d;
  cnt_t             alloc_q, alloc_d;
  cnt_t             drop_q, drop_d;

  cnt_t             filled_cnt;
  cnt_t             unfilled_cnt;
  cnt_t             drop_sum;
  logic [CW:0]      credit_sum;
  logic             req_fire;
  logic             rsp_drop;
  logic             rsp_fill;
  logic             deq;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      filled_cnt = filled_cnt + cnt_t'(slot_filled_q[i]);
    end
  end

  // Requests issued but not yet answered; these become stale on a redirect.
  assign unfilled_cnt = alloc_q - filled_cnt;
  assign credit_sum   = {1'b0, alloc_q} + {1'b0, drop_q};

  assign IMemReqValid_o = !reset_i && !redirect_i && (credit_sum < DEPTH_W);
  assign IMemAddr_o     = reset_i ? RESET_PC : fetch_pc_q;
  assign FD_valid_o     = !reset_i && !redirect_i && slot_filled_q[head_q];
  assign FD_PC_o        = reset_i ? '0 : slot_pc_q[head_q];
  assign FD_instr_o     = reset_i ? '0 : slot_instr_q[head_q];

  assign req_fire = IMemReqValid_o && IMemReqReady_i;
  assign rsp_drop = IMemRspValid_i && (drop_q != '0);
  assign rsp_fill = IMemRspValid_i && (drop_q == '0) && (unfilled_cnt != '0);
  assign deq      = FD_valid_o && FD_ready_i;
  assign drop_sum = drop_q + unfilled_cnt;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    slot_pc_d     = slot_pc_q;
    slot_instr_d  = slot_instr_q;
    slot_filled_d = slot_filled_q;
    head_d        = head_q;
    fill_d        = fill_q;
    tail_d        = tail_q;
    alloc_d       = alloc_q;
    drop_d        = drop_q;
    if (redirect_i) begin
      slot_filled_d = '0;
      head_d        = '0;
      fill_d        = '0;
      tail_d        = '0;
      alloc_d       = '0;
      // A response arriving now is the oldest outstanding one and is already consumed.
      if (IMemRspValid_i && (drop_sum != '0)) drop_d = drop_sum - cnt_t'(1);
      else                                    drop_d = drop_sum;
      fetch_pc_d = {redirectPC_i[31:2], 2'b00};
    end else begin
      if (req_fire) begin
        slot_pc_d[tail_q]     = fetch_pc_q;
        slot_filled_d[tail_q] = 1'b0;
        tail_d                = tail_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (rsp_drop) drop_d = drop_q - 1'b1;
      if (rsp_fill) begin
        slot_instr_d[fill_q]  = IMemRspData_i;
        slot_filled_d[fill_q] = 1'b1;
        fill_d                = fill_q + 1'b1;
      end
      if (deq) begin
        slot_filled_d[head_q] = 1'b0;
        head_d                = head_q + 1'b1;
      end
      alloc_d = alloc_q + cnt_t'(req_fire) - cnt_t'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      slot_filled_q <= '0;
      head_q        <= '0;
      fill_q        <= '0;
      tail_q        <= '0;
      alloc_q       <= '0;
      drop_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slot_pc_q[i]    <= '0;
        slot_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      slot_pc_q     <= slot_pc_d;
      slot_instr_q  <= slot_instr_d;
      slot_filled_q <= slot_filled_d;
      head_q        <= head_d;
      fill_q        <= fill_d;
      tail_q        <= tail_d;
      alloc_q       <= alloc_d;
      drop_q        <= drop_d;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_empty_q;
  logic [31:0] perf_drop_q;
  logic        rsp_discard;

  // Responses swallowed by a redirect in the same cycle are discarded too.
  assign rsp_discard = rsp_drop || (IMemRspValid_i && redirect_i && (unfilled_cnt != '0));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      perf_empty_q <= '0;
      perf_drop_q  <= '0;
    end else begin
      if (!FD_valid_o && (perf_empty_q != 32'hFFFF_FFFF)) perf_empty_q <= perf_empty_q + 32'd1;
      if (rsp_discard && (perf_drop_q != 32'hFFFF_FFFF)) perf_drop_q <= perf_drop_q + 32'd1;
    end
  end

  assign perfEmptyCycles_o = perf_empty_q;
  assign perfDropped_o     = perf_drop_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model with fixed latency, expected PCs queued on fire.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        redirect_i;
  logic [31:0] redirectPC_i;
  logic        IMemReqValid_o;
  logic        IMemReqReady_i;
  logic [31:0] IMemAddr_o;
  logic        IMemRspValid_i;
  logic [31:0] IMemRspData_i;
  logic        FD_valid_o;
  logic        FD_ready_i;
  logic [31:0] FD_PC_o;
  logic [31:0] FD_instr_o;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perfEmptyCycles_o;
  logic [31:0] perfDropped_o;
`endif

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .redirect_i     (redirect_i),
    .redirectPC_i   (redirectPC_i),
    .IMemReqValid_o (IMemReqValid_o),
    .IMemReqReady_i (IMemReqReady_i),
    .IMemAddr_o     (IMemAddr_o),
    .IMemRspValid_i (IMemRspValid_i),
    .IMemRspData_i  (IMemRspData_i),
    .FD_valid_o     (FD_valid_o),
    .FD_ready_i     (FD_ready_i),
    .FD_PC_o        (FD_PC_o),
    .FD_instr_o     (FD_instr_o)
`ifdef FETCH_QUEUE_PERF_EN
    ,
    .perfEmptyCycles_o (perfEmptyCycles_o),
    .perfDropped_o     (perfDropped_o)
`endif
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } mem_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  int          fire_cnt = 0;
  int          deq_cnt  = 0;
  logic [31:0] exp_pc   = RESET_PC;
  logic [31:0] sb_q[$];
  mem_t        mem_q[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
  endfunction

  // One clock cycle: observe handshakes mid-cycle, clock, then drive next memory response.
  task automatic run_cycle();
    logic        fire, dq, rst, rdr;
    logic [31:0] rpc, want;
    #1;
    rst  = reset_i;
    rdr  = redirect_i;
    rpc  = redirectPC_i;
    fire = IMemReqValid_o && IMemReqReady_i;
    dq   = FD_valid_o && FD_ready_i;
    if (!rst && fire) begin
      n_checks++;
      if (IMemAddr_o !== exp_pc)
        $display("FAIL req_addr: got %h want %h (cycle %0d)", IMemAddr_o, exp_pc, cyc);
      else n_pass++;
      mem_q.push_back('{data: instr_of(IMemAddr_o), due: cyc + lat});
      sb_q.push_back(exp_pc);
      exp_pc = exp_pc + 32'd4;
      fire_cnt++;
    end
    if (!rst && dq) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL deliver_unexpected: got pc %h with empty scoreboard (cycle %0d)", FD_PC_o, cyc);
      end else begin
        want = sb_q.pop_front();
        if (FD_PC_o !== want || FD_instr_o !== instr_of(want))
          $display("FAIL deliver: got pc %h instr %h want pc %h instr %h (cycle %0d)",
                   FD_PC_o, FD_instr_o, want, instr_of(want), cyc);
        else n_pass++;
      end
      deq_cnt++;
    end
    if (rst) begin
      exp_pc = RESET_PC;
      sb_q.delete();
    end else if (rdr) begin
      exp_pc = {rpc[31:2], 2'b00};
      sb_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) mem_q.delete();
    IMemRspValid_i = 1'b0;
    IMemRspData_i  = 32'h0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      IMemRspValid_i = 1'b1;
      IMemRspData_i  = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i        = 1'b1;
    redirect_i     = 1'b0;
    redirectPC_i   = 32'h0;
    IMemReqReady_i = 1'b1;
    FD_ready_i     = 1'b1;
    run_cycle();
    run_cycle();
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", IMemReqValid_o); else n_pass++;
    n_checks++; if (FD_valid_o !== 1'b0) $display("FAIL rst_fd_valid: got %b want 0", FD_valid_o); else n_pass++;
    n_checks++; if (IMemAddr_o !== RESET_PC) $display("FAIL rst_addr: got %h want %h", IMemAddr_o, RESET_PC); else n_pass++;
    n_checks++; if (FD_PC_o !== 32'h0) $display("FAIL rst_fd_pc: got %h want 0", FD_PC_o); else n_pass++;
    n_checks++; if (FD_instr_o !== 32'h0) $display("FAIL rst_fd_instr: got %h want 0", FD_instr_o); else n_pass++;
    run_cycle();
    run_cycle();
    reset_i = 1'b0;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b1) $display("FAIL post_rst_req_valid: got %b want 1", IMemReqValid_o); else n_pass++;
    n_checks++; if (IMemAddr_o !== RESET_PC) $display("FAIL post_rst_addr: got %h want %h", IMemAddr_o, RESET_PC); else n_pass++;
    n_checks++; if (FD_valid_o !== 1'b0) $display("FAIL post_rst_fd_valid: got %b want 0", FD_valid_o); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    lat     = 1;
    deq_cnt = 0;
    repeat (20) run_cycle();
    n_checks++; if (deq_cnt != 18) $display("FAIL stream_throughput: got %0d want 18", deq_cnt); else n_pass++;
  endtask

  task automatic test_full_stall();
    do_reset();
    lat        = 1;
    FD_ready_i = 1'b0;
    fire_cnt   = 0;
    repeat (8) run_cycle();
    n_checks++; if (fire_cnt != DEPTH) $display("FAIL full_fire_count: got %0d want %0d", fire_cnt, DEPTH); else n_pass++;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b0) $display("FAIL full_req_valid: got %b want 0", IMemReqValid_o); else n_pass++;
    n_checks++; if (FD_valid_o !== 1'b1 || FD_PC_o !== 32'h0)
      $display("FAIL full_head: got valid %b pc %h want valid 1 pc 00000000", FD_valid_o, FD_PC_o); else n_pass++;
    FD_ready_i = 1'b1;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b0) $display("FAIL full_deq_req_valid: got %b want 0", IMemReqValid_o); else n_pass++;
    run_cycle();
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b1 || IMemAddr_o !== 32'h10)
      $display("FAIL freed_slot_req: got valid %b addr %h want valid 1 addr 00000010", IMemReqValid_o, IMemAddr_o); else n_pass++;
    repeat (6) run_cycle();
  endtask

  task automatic test_redirect();
    do_reset();
    lat = 4;
    repeat (3) run_cycle();
    redirect_i   = 1'b1;
    redirectPC_i = 32'h0000_0203;
    #1;
    n_checks++; if (FD_valid_o !== 1'b0) $display("FAIL redir_fd_valid: got %b want 0", FD_valid_o); else n_pass++;
    n_checks++; if (IMemReqValid_o !== 1'b0) $display("FAIL redir_req_valid: got %b want 0", IMemReqValid_o); else n_pass++;
    run_cycle();
    redirect_i = 1'b0;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b1 || IMemAddr_o !== 32'h200)
      $display("FAIL redir_new_req: got valid %b addr %h want valid 1 addr 00000200", IMemReqValid_o, IMemAddr_o); else n_pass++;
    deq_cnt = 0;
    repeat (12) run_cycle();
    n_checks++; if (deq_cnt < 4) $display("FAIL redir_delivered: got %0d want at least 4", deq_cnt); else n_pass++;
`ifdef FETCH_QUEUE_PERF_EN
    n_checks++; if (perfDropped_o !== 32'd3) $display("FAIL perf_dropped: got %0d want 3", perfDropped_o); else n_pass++;
`endif
  endtask

  task automatic test_redirect_rsp();
    do_reset();
    lat = 2;
    repeat (2) run_cycle();
    n_checks++; if (IMemRspValid_i !== 1'b1) $display("FAIL redir_rsp_setup: got rsp valid %b want 1", IMemRspValid_i); else n_pass++;
    redirect_i   = 1'b1;
    redirectPC_i = 32'h0000_0300;
    run_cycle();
    redirect_i = 1'b0;
    run_cycle();
    #1;
    n_checks++; if (FD_valid_o !== 1'b0) $display("FAIL stale_rsp_dropped: got fd valid %b pc %h want 0", FD_valid_o, FD_PC_o); else n_pass++;
    run_cycle();
    run_cycle();
    #1;
    n_checks++; if (FD_valid_o !== 1'b1 || FD_PC_o !== 32'h300)
      $display("FAIL redir_rsp_first: got valid %b pc %h want valid 1 pc 00000300", FD_valid_o, FD_PC_o); else n_pass++;
    repeat (4) run_cycle();
  endtask

  task automatic test_mem_stall();
    do_reset();
    lat            = 1;
    fire_cnt       = 0;
    IMemReqReady_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (IMemReqValid_o !== 1'b1 || IMemAddr_o !== RESET_PC)
        $display("FAIL mem_stall_hold: got valid %b addr %h want valid 1 addr %h (stall %0d)", IMemReqValid_o, IMemAddr_o, RESET_PC, i); else n_pass++;
      run_cycle();
    end
    n_checks++; if (fire_cnt != 0) $display("FAIL mem_stall_fires: got %0d want 0", fire_cnt); else n_pass++;
    IMemReqReady_i = 1'b1;
    repeat (6) run_cycle();
  endtask

  task automatic test_mid_reset();
    do_reset();
    lat        = 1;
    FD_ready_i = 1'b0;
    repeat (6) run_cycle();
    #1;
    n_checks++; if (FD_valid_o !== 1'b1 || IMemReqValid_o !== 1'b0)
      $display("FAIL mid_full: got fd valid %b req valid %b want 1 0", FD_valid_o, IMemReqValid_o); else n_pass++;
    redirect_i = 1'b1;
    #1;
    n_checks++; if (FD_valid_o !== 1'b0) $display("FAIL redir_masks_valid: got %b want 0", FD_valid_o); else n_pass++;
    redirect_i = 1'b0;
    reset_i    = 1'b1;
    #1;
    n_checks++; if (IMemReqValid_o !== 1'b0 || FD_valid_o !== 1'b0 || FD_PC_o !== 32'h0 || FD_instr_o !== 32'h0)
      $display("FAIL mid_rst_outputs: got req %b fd %b pc %h instr %h want 0 0 0 0", IMemReqValid_o, FD_valid_o, FD_PC_o, FD_instr_o); else n_pass++;
    run_cycle();
    reset_i = 1'b0;
    #1;
    n_checks++; if (FD_valid_o !== 1'b0 || IMemAddr_o !== RESET_PC || IMemReqValid_o !== 1'b1)
      $display("FAIL mid_rst_after: got fd %b addr %h req %b want 0 %h 1", FD_valid_o, IMemAddr_o, IMemReqValid_o, RESET_PC); else n_pass++;
    FD_ready_i = 1'b1;
    deq_cnt    = 0;
    repeat (6) run_cycle();
    n_checks++; if (deq_cnt != 4) $display("FAIL mid_rst_resume: got %0d deliveries want 4", deq_cnt); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    lat     = 2;
    deq_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      IMemReqReady_i = ($urandom_range(0, 3) != 0);
      FD_ready_i     = ($urandom_range(0, 3) != 0);
      redirect_i     = ($urandom_range(0, 19) == 0);
      redirectPC_i   = $urandom & 32'h0000_FFFF;
      run_cycle();
    end
    redirect_i     = 1'b0;
    IMemReqReady_i = 1'b1;
    FD_ready_i     = 1'b1;
    repeat (10) run_cycle();
    n_checks++; if (deq_cnt < 30) $display("FAIL random_progress: got %0d deliveries want at least 30", deq_cnt); else n_pass++;
  endtask

  initial begin
    reset_i        = 1'b1;
    redirect_i     = 1'b0;
    redirectPC_i   = 32'h0;
    IMemReqReady_i = 1'b1;
    IMemRspValid_i = 1'b0;
    IMemRspData_i  = 32'h0;
    FD_ready_i     = 1'b1;
    @(negedge clk);
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_redirect_rsp();
    test_mem_stall();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised, decoupled instruction-fetch front end for the pipelined RV32 core; generalises the single-entry F→D register to a DEPTH-entry in-order queue.
- Supports a variable-latency instruction memory with valid/ready request and valid-only in-order response, plus up to DEPTH requests in flight.
- Handles redirects from branch prediction (decode) and misprediction correction (execute) by flushing the queue and discarding stale in-flight responses.
- Sits between instruction memory and the decode stage.

Parameters:
DEPTH, 4, queue entries and maximum in-flight requests; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
redirect_i  input  1  flush queue and restart fetch at redirectPC_i
redirectPC_i  input  32  new fetch PC; bits [1:0] ignored, treated as 0
IMemReqValid_o  output  1  fetch request valid
IMemReqReady_i  input  1  memory accepts request
IMemAddr_o  output  32  request address, word aligned
IMemRspValid_i  input  1  response valid; responses return in request order
IMemRspData_i  input  32  instruction word
FD_valid_o  output  1  head entry holds a fetched instruction
FD_ready_i  input  1  decode consumes head (low = decode stall)
FD_PC_o  output  32  PC of head entry
FD_instr_o  output  32  instruction of head entry

Behaviour:
- State: fetchPC; DEPTH slots {pc, instr, filled}; head, fill and tail pointers (log2 DEPTH bits, wrap modulo DEPTH); alloc count 0..DEPTH; dropCount 0..DEPTH.
- Reset: fetchPC=RESET_PC, pointers=0, alloc=0, dropCount=0, all filled=0. While reset_i is high: IMemReqValid_o=0, FD_valid_o=0, IMemAddr_o=RESET_PC, FD_PC_o=0, FD_instr_o=0. A mid-operation reset discards everything, including in-flight accounting. Memory is reset on the same reset.
- Credit: IMemReqValid_o = !reset_i && !redirect_i && (alloc + dropCount < DEPTH), computed from registered state only. It never depends on FD_ready_i.
- IMemAddr_o = fetchPC.
- Request fire (valid && ready):
  - slot[tail].pc = fetchPC, filled=0.
  - tail++, alloc++.
  - fetchPC += 4, wrapping modulo 2^32.
- Response, when dropCount > 0: discard it and decrement dropCount.
- Response, when dropCount = 0: write slot[fill].instr, set filled=1, fill++.
- A response with no unfilled slot and dropCount = 0 is a protocol error. Ignore it; the state is unchanged.
- FD_valid_o = slot[head].filled && !redirect_i.
- FD_PC_o and FD_instr_o come from slot[head]. They hold their value while FD_ready_i is low.
- Dequeue when FD_valid_o && FD_ready_i: clear filled, head++, alloc--.
- Latency: a response in cycle N is visible on FD_valid_o in cycle N+1. No same-cycle bypass.
- Redirect (priority over request and dequeue):
  - Clear all slots; head=fill=tail=0; alloc=0.
  - dropCount_next = dropCount + (alloc − filledCount) − (IMemRspValid_i ? 1 : 0).
  - fetchPC = {redirectPC_i[31:2], 2'b00}.
  - The first request from the new PC is issued in cycle N+1.
- Simultaneous events:
  - Dequeue and request fire in the same cycle: alloc is unchanged.
  - Full queue with dequeue: the freed slot becomes requestable next cycle.
  - Response and dequeue in the same cycle touch different slots, since head is already filled.
- Full: alloc + dropCount = DEPTH, so IMemReqValid_o=0.
- Empty: alloc = 0 or head not filled, so FD_valid_o=0.

Optional Feature:
- Macro FETCH_QUEUE_PERF_EN.
- When defined, adds two outputs:
  - perfEmptyCycles_o (32): counts cycles with !reset_i && !FD_valid_o.
  - perfDropped_o (32): counts discarded responses.
- Both counters are cleared by reset and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, memory ready=1, 1-cycle response, FD_ready_i=1 → requests 0x0,0x4,0x8… on consecutive cycles; FD_PC_o sequence 0x0,0x4,0x8 with matching instr; one instruction delivered per cycle in steady state.
- DEPTH=4, FD_ready_i=0 → exactly 4 requests issued (0x0–0xC), then IMemReqValid_o=0; raise FD_ready_i → dequeue 0x0 in same cycle, next request 0x10 the following cycle.
- 3-cycle memory latency, 3 requests in flight, redirect_i=1 with redirectPC_i=0x200 → FD_valid_o=0 that cycle; next request addr 0x200; 3 stale responses dropped (perfDropped_o=3 with macro); first delivered FD_PC_o=0x200.
- Redirect coincident with response arrival, 2 unfilled slots → dropCount=1; exactly one further response discarded.
- IMemReqReady_i held 0 for 5 cycles → IMemReqValid_o and IMemAddr_o stable; fetchPC advances only on fire.
- reset_i asserted mid-stream with full queue → next cycle FD_valid_o=0, IMemAddr_o=RESET_PC; after release, fetch resumes at RESET_PC.
